// File: rtl/ssd_scan_2d.sv
// Two-digit multiplexed seven-segment scanner for a common-anode display.
// Frame-coherent shadow digits, optional leading-zero blanking and whole-display blink.
module ssd_scan_2d #(
  parameter int unsigned SCAN_CYCLES  = 100000,
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic       blink_en,
  input  logic       blank_lead,
  output logic [3:0] ssd_ctl,
  output logic [7:0] display
);

  localparam int unsigned SW = (SCAN_CYCLES  > 2) ? $clog2(SCAN_CYCLES)  : 1;
  localparam int unsigned BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

  logic [SW-1:0] scan_cnt;
  logic          pos;
  logic [3:0]    sh0;
  logic [3:0]    sh1;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          scan_wrap;
  logic          blink_wrap;
  logic          blank;
  logic [3:0]    ctl_next;
  logic [7:0]    disp_next;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'b0000_0011;
      4'd1:    seg7 = 8'b1001_1111;
      4'd2:    seg7 = 8'b0010_0101;
      4'd3:    seg7 = 8'b0000_1101;
      4'd4:    seg7 = 8'b1001_1001;
      4'd5:    seg7 = 8'b0100_1001;
      4'd6:    seg7 = 8'b0100_0001;
      4'd7:    seg7 = 8'b0001_1111;
      4'd8:    seg7 = 8'b0000_0001;
      4'd9:    seg7 = 8'b0000_1001;
      default: seg7 = 8'b1111_1101;
    endcase
  endfunction

  assign scan_wrap  = (scan_cnt == SW'(SCAN_CYCLES - 1));
  assign blink_wrap = (blink_cnt == BW'(BLINK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      pos      <= 1'b0;
      sh0      <= '0;
      sh1      <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      pos      <= ~pos;
      // Both digits are captured together on the 1->0 turn so a frame never tears.
      if (pos) begin
        sh0 <= digit0;
        sh1 <= digit1;
      end
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !blink_en) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_wrap) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_comb begin
    blank     = (blink_en && phase) || (pos && blank_lead && (sh1 == 4'd0));
    ctl_next  = 4'b1111;
    disp_next = '1;
    if (!blank) begin
      ctl_next  = pos ? 4'b1101 : 4'b1110;
      disp_next = seg7(pos ? sh1 : sh0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ssd_ctl <= 4'b1111;
      display <= '1;
    end else begin
      ssd_ctl <= ctl_next;
      display <= disp_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan_2d.sv
// Directed self-checking bench for ssd_scan_2d with SCAN_CYCLES=4, BLINK_CYCLES=10.
// k counts edges since reset release (k=0 is the first non-reset edge).
module tb_ssd_scan_2d;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit0 = '0;
  logic [3:0] digit1 = '0;
  logic       blink_en = 1'b0;
  logic       blank_lead = 1'b0;
  logic [3:0] ssd_ctl;
  logic [7:0] display;

  int checks = 0;
  int errors = 0;
  int k = -1;

  ssd_scan_2d #(.SCAN_CYCLES(4), .BLINK_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .digit0(digit0), .digit1(digit1),
    .blink_en(blink_en), .blank_lead(blank_lead),
    .ssd_ctl(ssd_ctl), .display(display)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_seg(input int d);
    case (d)
      0: ref_seg = 8'b0000_0011;  1: ref_seg = 8'b1001_1111;
      2: ref_seg = 8'b0010_0101;  3: ref_seg = 8'b0000_1101;
      4: ref_seg = 8'b1001_1001;  5: ref_seg = 8'b0100_1001;
      6: ref_seg = 8'b0100_0001;  7: ref_seg = 8'b0001_1111;
      8: ref_seg = 8'b0000_0001;  9: ref_seg = 8'b0000_1001;
      default: ref_seg = 8'b1111_1101;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic tick_to(input int target);
    while (k < target) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    k = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      digit0 = 4'($urandom_range(0, 15));
      digit1 = 4'($urandom_range(0, 15));
      blink_en = 1'($urandom_range(0, 1));
      blank_lead = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checks++;
      if (ssd_ctl !== 4'b1111 || display !== 8'hFF) begin
        errors++;
        $display("FAIL reset_hold[%0d]: ctl=%b disp=%b, want 1111 11111111", i, ssd_ctl, display);
      end
    end
    digit0 = '0; digit1 = '0; blink_en = 1'b0; blank_lead = 1'b0;
    rst = 1'b0;
    k = -1;
    tick_to(1);
    checks++;
    if (ssd_ctl !== 4'b1110 || display !== 8'b0000_0011) begin
      errors++;
      $display("FAIL reset_release: ctl=%b disp=%b, want 1110 00000011", ssd_ctl, display);
    end
    // Reset mid-scan while position 1 is active must return to position 0.
    digit0 = 4'd8; digit1 = 4'd8;
    tick_to(6);
    rst = 1'b1;
    tick();
    checks++;
    if (ssd_ctl !== 4'b1111 || display !== 8'hFF) begin
      errors++;
      $display("FAIL reset_midscan: ctl=%b disp=%b, want 1111 11111111", ssd_ctl, display);
    end
    rst = 1'b0;
    k = -1;
    tick_to(1);
    checks++;
    if (ssd_ctl !== 4'b1110 || display !== 8'b0000_0011) begin
      errors++;
      $display("FAIL reset_midscan_release: ctl=%b disp=%b, want 1110 00000011", ssd_ctl, display);
    end
  endtask

  task automatic test_scan_decode();
    do_reset();
    digit1 = 4'd4; digit0 = 4'd7; blank_lead = 1'b0; blink_en = 1'b0;
    tick_to(3);
    checks++;
    if (ssd_ctl !== 4'b1110 || display !== 8'b0000_0011) begin
      errors++;
      $display("FAIL scan_preload_pos0: ctl=%b disp=%b, want 1110 00000011", ssd_ctl, display);
    end
    tick_to(4);
    checks++;
    if (ssd_ctl !== 4'b1101 || display !== 8'b0000_0011) begin
      errors++;
      $display("FAIL scan_preload_pos1: ctl=%b disp=%b, want 1101 00000011", ssd_ctl, display);
    end
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 4; c++) begin
        tick_to(8 + 8 * f + c);
        checks++;
        if (ssd_ctl !== 4'b1110 || display !== 8'b0001_1111) begin
          errors++;
          $display("FAIL scan_pos0 k=%0d: ctl=%b disp=%b, want 1110 00011111", k, ssd_ctl, display);
        end
      end
      for (int c = 0; c < 4; c++) begin
        tick_to(12 + 8 * f + c);
        checks++;
        if (ssd_ctl !== 4'b1101 || display !== 8'b1001_1001) begin
          errors++;
          $display("FAIL scan_pos1 k=%0d: ctl=%b disp=%b, want 1101 10011001", k, ssd_ctl, display);
        end
      end
    end
  endtask

  task automatic test_decode_all();
    do_reset();
    for (int d = 0; d < 16; d++) begin
      digit0 = 4'(d);
      digit1 = 4'(15 - d);
      tick_to(8 + 8 * d);
      checks++;
      if (ssd_ctl !== 4'b1110 || display !== ref_seg(d)) begin
        errors++;
        $display("FAIL decode_d0=%0d: ctl=%b disp=%b, want 1110 %b", d, ssd_ctl, display, ref_seg(d));
      end
      tick_to(12 + 8 * d);
      checks++;
      if (ssd_ctl !== 4'b1101 || display !== ref_seg(15 - d)) begin
        errors++;
        $display("FAIL decode_d1=%0d: ctl=%b disp=%b, want 1101 %b", 15 - d, ssd_ctl, display, ref_seg(15 - d));
      end
    end
  endtask

  task automatic test_frame_coherence();
    do_reset();
    digit1 = 4'd1; digit0 = 4'd9;
    tick_to(9);
    digit0 = 4'd3;
    tick_to(11);
    checks++;
    if (ssd_ctl !== 4'b1110 || display !== 8'b0000_1001) begin
      errors++;
      $display("FAIL coherence_hold: ctl=%b disp=%b, want 1110 00001001", ssd_ctl, display);
    end
    tick_to(13);
    digit0 = 4'd6;
    tick_to(16);
    checks++;
    if (ssd_ctl !== 4'b1110 || display !== 8'b0100_0001) begin
      errors++;
      $display("FAIL coherence_load: ctl=%b disp=%b, want 1110 01000001", ssd_ctl, display);
    end
    digit0 = 4'd3;
    tick_to(19);
    checks++;
    if (display !== 8'b0100_0001) begin
      errors++;
      $display("FAIL coherence_hold2: disp=%b, want 01000001", display);
    end
    tick_to(24);
    checks++;
    if (ssd_ctl !== 4'b1110 || display !== 8'b0000_1101) begin
      errors++;
      $display("FAIL coherence_next: ctl=%b disp=%b, want 1110 00001101", ssd_ctl, display);
    end
  endtask

  task automatic test_leading_blank();
    do_reset();
    digit1 = 4'd0; digit0 = 4'd5; blank_lead = 1'b1;
    tick_to(8);
    checks++;
    if (ssd_ctl !== 4'b1110 || display !== 8'b0100_1001) begin
      errors++;
      $display("FAIL blank_pos0: ctl=%b disp=%b, want 1110 01001001", ssd_ctl, display);
    end
    tick_to(12);
    checks++;
    if (ssd_ctl !== 4'b1111 || display !== 8'hFF) begin
      errors++;
      $display("FAIL blank_pos1: ctl=%b disp=%b, want 1111 11111111", ssd_ctl, display);
    end
    tick_to(13);
    blank_lead = 1'b0;
    checks++;
    if (ssd_ctl !== 4'b1111 || display !== 8'hFF) begin
      errors++;
      $display("FAIL blank_still: ctl=%b disp=%b, want 1111 11111111", ssd_ctl, display);
    end
    tick_to(14);
    checks++;
    if (ssd_ctl !== 4'b1101 || display !== 8'b0000_0011) begin
      errors++;
      $display("FAIL blank_off: ctl=%b disp=%b, want 1101 00000011", ssd_ctl, display);
    end
    blank_lead = 1'b1;
    digit1 = 4'd2;
    tick_to(20);
    checks++;
    if (ssd_ctl !== 4'b1101 || display !== 8'b0010_0101) begin
      errors++;
      $display("FAIL blank_nonzero: ctl=%b disp=%b, want 1101 00100101", ssd_ctl, display);
    end
  endtask

  task automatic test_blink();
    do_reset();
    digit1 = 4'd0; digit0 = 4'd0; blank_lead = 1'b0; blink_en = 1'b1;
    tick_to(9);
    checks++;
    if (ssd_ctl !== 4'b1110 || display !== 8'b0000_0011) begin
      errors++;
      $display("FAIL blink_vis_end: ctl=%b disp=%b, want 1110 00000011", ssd_ctl, display);
    end
    tick_to(10);
    checks++;
    if (ssd_ctl !== 4'b1111 || display !== 8'hFF) begin
      errors++;
      $display("FAIL blink_dark_start: ctl=%b disp=%b, want 1111 11111111", ssd_ctl, display);
    end
    tick_to(19);
    checks++;
    if (ssd_ctl !== 4'b1111 || display !== 8'hFF) begin
      errors++;
      $display("FAIL blink_dark_end: ctl=%b disp=%b, want 1111 11111111", ssd_ctl, display);
    end
    tick_to(20);
    checks++;
    if (ssd_ctl !== 4'b1101 || display !== 8'b0000_0011) begin
      errors++;
      $display("FAIL blink_vis2: ctl=%b disp=%b, want 1101 00000011", ssd_ctl, display);
    end
    tick_to(30);
    checks++;
    if (ssd_ctl !== 4'b1111 || display !== 8'hFF) begin
      errors++;
      $display("FAIL blink_dark2: ctl=%b disp=%b, want 1111 11111111", ssd_ctl, display);
    end
    tick_to(32);
    blink_en = 1'b0;
    tick_to(33);
    checks++;
    if (ssd_ctl !== 4'b1110 || display !== 8'b0000_0011) begin
      errors++;
      $display("FAIL blink_drop: ctl=%b disp=%b, want 1110 00000011", ssd_ctl, display);
    end
    tick_to(35);
    blink_en = 1'b1;
    tick_to(45);
    checks++;
    if (ssd_ctl !== 4'b1101 || display !== 8'b0000_0011) begin
      errors++;
      $display("FAIL blink_restart_vis: ctl=%b disp=%b, want 1101 00000011", ssd_ctl, display);
    end
    tick_to(46);
    checks++;
    if (ssd_ctl !== 4'b1111 || display !== 8'hFF) begin
      errors++;
      $display("FAIL blink_restart_dark: ctl=%b disp=%b, want 1111 11111111", ssd_ctl, display);
    end
    blink_en = 1'b0;
  endtask

  task automatic test_invalid_bcd();
    do_reset();
    digit1 = 4'd3; digit0 = 4'hC; blank_lead = 1'b1;
    tick_to(8);
    checks++;
    if (ssd_ctl !== 4'b1110 || display !== 8'b1111_1101) begin
      errors++;
      $display("FAIL invalid_bcd: ctl=%b disp=%b, want 1110 11111101", ssd_ctl, display);
    end
    tick_to(12);
    checks++;
    if (ssd_ctl !== 4'b1101 || display !== 8'b0000_1101) begin
      errors++;
      $display("FAIL invalid_pos1: ctl=%b disp=%b, want 1101 00001101", ssd_ctl, display);
    end
  endtask

  initial begin
    test_reset();
    test_scan_decode();
    test_decode_all();
    test_frame_coherence();
    test_leading_blank();
    test_blink();
    test_invalid_bcd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
